// File: rtl/sakebi_ethernet_frame_tx_if.sv
// Byte-wide AXI-Stream bundle used on both sides of the Ethernet frame
// transmitter. The master drives data/valid/last, the slave drives ready.
interface sakebi_ethernet_frame_tx_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  TVALID;
  logic                  TREADY;
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;

  modport master (
    output TVALID,
    output TDATA,
    output TLAST,
    input  TREADY
  );

  modport slave (
    input  TVALID,
    input  TDATA,
    input  TLAST,
    output TREADY
  );

endinterface : sakebi_ethernet_frame_tx_if

// File: rtl/sakebi_ethernet_frame_tx.sv
// Ethernet II frame transmitter.
// Serialises dst MAC, src MAC and EtherType (low byte of each field first),
// forwards the byte-wide payload and optionally zero-pads the payload up to
// MIN_PAYLOAD bytes. A single output register carries TDATA/TLAST/TVALID and
// advances whenever it is empty or the downstream accepts the current byte.
// FCS is not generated here.
module sakebi_ethernet_frame_tx #(
  parameter int DATA_WIDTH      = 8,
  parameter int MAC_ADDR_WIDTH  = DATA_WIDTH * 6,
  parameter int ETHERTYPE_WIDTH = DATA_WIDTH * 2,
  parameter int MIN_PAYLOAD     = 46,
  parameter bit PAD_EN          = 1'b1
) (
  input  logic                       i_axis_ACLK,
  input  logic                       i_axis_ARESET,
  sakebi_ethernet_frame_tx_if.slave  s_axis,
  sakebi_ethernet_frame_tx_if.master m_axis,
  input  logic [MAC_ADDR_WIDTH-1:0]  i_dst_mac_addr,
  input  logic [MAC_ADDR_WIDTH-1:0]  i_src_mac_addr,
  input  logic [ETHERTYPE_WIDTH-1:0] i_ethertype,
  input  logic                       i_specify_mac_en,
  input  logic [MAC_ADDR_WIDTH-1:0]  i_mac_addr,
  output logic                       o_busy
);

  // Payload counter only needs to reach MIN_PAYLOAD; it saturates there.
  localparam int                CNT_W        = $clog2(MIN_PAYLOAD + 1);
  localparam logic [CNT_W-1:0]  MIN_CNT      = CNT_W'(MIN_PAYLOAD);
  localparam logic [CNT_W-1:0]  CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [2:0]        LAST_MAC_IDX = 3'd5;

  // Each state names the field the next loaded output byte comes from.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DST     = 3'd1,
    ST_SRC     = 3'd2,
    ST_TYPE    = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_PAD     = 3'd5
  } state_t;

  state_t                      state_r, state_s;
  logic [2:0]                  idx_r, idx_s;
  logic [CNT_W-1:0]            cnt_r, cnt_s;
  logic [MAC_ADDR_WIDTH-1:0]   dst_r, dst_s;
  logic [MAC_ADDR_WIDTH-1:0]   src_r, src_s;
  logic [ETHERTYPE_WIDTH-1:0]  type_r, type_s;
  logic [DATA_WIDTH-1:0]       tdata_r, tdata_s;
  logic                        tlast_r, tlast_s;
  logic                        tvalid_r, tvalid_s;
  logic                        busy_r, busy_s;
  logic                        tready_s;
  logic                        load_s;
  logic [CNT_W-1:0]            cnt_inc_s;
  logic                        cnt_full_s;
  logic [MAC_ADDR_WIDTH-1:0]   src_sel_s;

  // Byte idx of a MAC address, byte 0 being bits [DATA_WIDTH-1:0].
  function automatic logic [DATA_WIDTH-1:0] mac_byte(
    input logic [MAC_ADDR_WIDTH-1:0] addr,
    input logic [2:0]                idx
  );
    mac_byte = addr[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Byte idx (0 or 1) of the EtherType, low byte first.
  function automatic logic [DATA_WIDTH-1:0] type_byte(
    input logic [ETHERTYPE_WIDTH-1:0] etype,
    input logic                       idx
  );
    type_byte = etype[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // The output register may take a new byte when empty or being drained.
  assign load_s     = !tvalid_r || m_axis.TREADY;
  assign cnt_inc_s  = (cnt_r >= MIN_CNT) ? MIN_CNT : (cnt_r + CNT_ONE);
  assign cnt_full_s = (cnt_inc_s >= MIN_CNT);
  assign src_sel_s  = i_specify_mac_en ? i_mac_addr : i_src_mac_addr;

  // Next-state, header sequencing, output-register load and input handshake
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    cnt_s    = cnt_r;
    dst_s    = dst_r;
    src_s    = src_r;
    type_s   = type_r;
    tdata_s  = tdata_r;
    tlast_s  = tlast_r;
    tready_s = 1'b0;
    // The TLAST byte leaving clears busy; a same-edge restart sets it again below.
    busy_s   = busy_r & ~(tvalid_r & tlast_r & m_axis.TREADY);
    if (load_s) begin
      tvalid_s = 1'b0;
    end else begin
      tvalid_s = tvalid_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (s_axis.TVALID && load_s) begin
          dst_s    = i_dst_mac_addr;
          src_s    = src_sel_s;
          type_s   = i_ethertype;
          tdata_s  = mac_byte(i_dst_mac_addr, 3'd0);
          tlast_s  = 1'b0;
          tvalid_s = 1'b1;
          idx_s    = 3'd1;
          cnt_s    = CNT_ZERO;
          busy_s   = 1'b1;
          state_s  = ST_DST;
        end else begin
          state_s  = ST_IDLE;
        end
      end

      ST_DST: begin
        if (load_s) begin
          tdata_s  = mac_byte(dst_r, idx_r);
          tlast_s  = 1'b0;
          tvalid_s = 1'b1;
          if (idx_r == LAST_MAC_IDX) begin
            idx_s   = 3'd0;
            state_s = ST_SRC;
          end else begin
            idx_s   = idx_r + 3'd1;
          end
        end else begin
          state_s = ST_DST;
        end
      end

      ST_SRC: begin
        if (load_s) begin
          tdata_s  = mac_byte(src_r, idx_r);
          tlast_s  = 1'b0;
          tvalid_s = 1'b1;
          if (idx_r == LAST_MAC_IDX) begin
            idx_s   = 3'd0;
            state_s = ST_TYPE;
          end else begin
            idx_s   = idx_r + 3'd1;
          end
        end else begin
          state_s = ST_SRC;
        end
      end

      ST_TYPE: begin
        if (load_s) begin
          tdata_s  = type_byte(type_r, idx_r[0]);
          tlast_s  = 1'b0;
          tvalid_s = 1'b1;
          if (idx_r[0]) begin
            idx_s   = 3'd0;
            state_s = ST_PAYLOAD;
          end else begin
            idx_s   = 3'd1;
          end
        end else begin
          state_s = ST_TYPE;
        end
      end

      ST_PAYLOAD: begin
        // Input bytes pass straight into the output register, so ready
        // simply mirrors whether that register can take one.
        tready_s = load_s;
        if (s_axis.TVALID && load_s) begin
          tdata_s  = s_axis.TDATA;
          tvalid_s = 1'b1;
          cnt_s    = cnt_inc_s;
          if (s_axis.TLAST) begin
            if ((PAD_EN == 1'b0) || cnt_full_s) begin
              tlast_s = 1'b1;
              state_s = ST_IDLE;
            end else begin
              tlast_s = 1'b0;
              state_s = ST_PAD;
            end
          end else begin
            tlast_s = 1'b0;
          end
        end else begin
          state_s = ST_PAYLOAD;
        end
      end

      ST_PAD: begin
        if (load_s) begin
          tdata_s  = {DATA_WIDTH{1'b0}};
          tvalid_s = 1'b1;
          cnt_s    = cnt_inc_s;
          if (cnt_full_s) begin
            tlast_s = 1'b1;
            state_s = ST_IDLE;
          end else begin
            tlast_s = 1'b0;
          end
        end else begin
          state_s = ST_PAD;
        end
      end

      default: begin
        state_s  = ST_IDLE;
        tvalid_s = 1'b0;
        tlast_s  = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  // State, latched header, counters and the single output register
  always_ff @(posedge i_axis_ACLK) begin
    if (i_axis_ARESET) begin
      state_r  <= ST_IDLE;
      idx_r    <= 3'd0;
      cnt_r    <= CNT_ZERO;
      dst_r    <= {MAC_ADDR_WIDTH{1'b0}};
      src_r    <= {MAC_ADDR_WIDTH{1'b0}};
      type_r   <= {ETHERTYPE_WIDTH{1'b0}};
      tdata_r  <= {DATA_WIDTH{1'b0}};
      tlast_r  <= 1'b0;
      tvalid_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      cnt_r    <= cnt_s;
      dst_r    <= dst_s;
      src_r    <= src_s;
      type_r   <= type_s;
      tdata_r  <= tdata_s;
      tlast_r  <= tlast_s;
      tvalid_r <= tvalid_s;
      busy_r   <= busy_s;
    end
  end

  assign m_axis.TVALID = tvalid_r;
  assign m_axis.TDATA  = tdata_r;
  assign m_axis.TLAST  = tlast_r;
  assign s_axis.TREADY = tready_s;
  assign o_busy        = busy_r;

endmodule : sakebi_ethernet_frame_tx

// File: doc/sakebi_ethernet_frame_tx.md
Name: sakebi_ethernet_frame_tx

Overview:
Ethernet II frame transmitter, the TX counterpart of the frame receiver. It accepts a byte-wide AXI-Stream payload plus header fields and emits a complete byte-serial frame: dst MAC (6), src MAC (6), EtherType (2), payload, then zero padding up to the minimum payload length. It sits between upper-layer packet builders (IPv4/ARP TX) and the MAC/PHY TX path. No FCS; that is appended downstream.

Parameters:
DATA_WIDTH, 8, stream byte width (only 8 supported)
MAC_ADDR_WIDTH, DATA_WIDTH*6, MAC address width
ETHERTYPE_WIDTH, DATA_WIDTH*2, EtherType width
MIN_PAYLOAD, 46, minimum payload bytes; frames shorter are zero-padded
PAD_EN, 1, 1 = pad short payloads, 0 = no padding

Ports:
i_axis_ACLK  in  1  clock
i_axis_ARESET  in  1  synchronous reset, active-high
i_axis_TVALID  in  1  payload byte valid
o_axis_TREADY  out  1  payload byte accepted
i_axis_TDATA  in  DATA_WIDTH  payload byte
i_axis_TLAST  in  1  last payload byte of frame
o_axis_TVALID  out  1  frame byte valid
i_axis_TREADY  in  1  downstream ready
o_axis_TDATA  out  DATA_WIDTH  frame byte
o_axis_TLAST  out  1  last byte of frame
i_dst_mac_addr  in  MAC_ADDR_WIDTH  destination MAC; [7:0] sent first
i_src_mac_addr  in  MAC_ADDR_WIDTH  source MAC; [7:0] sent first
i_ethertype  in  ETHERTYPE_WIDTH  EtherType; [7:0] sent first
i_specify_mac_en  in  1  1 = use i_mac_addr as source MAC
i_mac_addr  in  MAC_ADDR_WIDTH  local MAC for source field
o_busy  out  1  high from frame start until TLAST byte accepted downstream

Behaviour:
- Clock and reset: one clock; synchronous, active-high reset. Reset forces state IDLE; o_axis_TVALID=0, o_axis_TDATA=0, o_axis_TLAST=0, o_axis_TREADY=0, o_busy=0; counters and latched header cleared. Reset mid-frame abandons the frame with no TLAST emitted.
- Byte order: field bit [7:0] goes on the wire first, then [15:8], and so on. This matches the receiver's shift-in order, so RX(TX(x)) returns x.
- Output register: a single register (TDATA/TLAST/TVALID). Define load = !o_axis_TVALID || i_axis_TREADY. On load with no new byte, o_axis_TVALID clears. Output holds stable while TVALID=1 and TREADY=0.
- States: IDLE, DST, SRC, TYPE, PAYLOAD, PAD.
- IDLE: o_axis_TREADY=0. If i_axis_TVALID=1 and load, it latches i_dst_mac_addr, the source MAC (i_mac_addr if i_specify_mac_en else i_src_mac_addr) and i_ethertype, loads dst byte0 into the output, moves to DST and sets o_busy. Header inputs are sampled only on this edge. The first byte appears 1 cycle after the start edge.
- DST/SRC: emit 6 bytes each, one per load. SRC byte0 loads on the load after DST byte5.
- TYPE: emits 2 bytes, then moves to PAYLOAD.
- PAYLOAD: o_axis_TREADY = load (combinational). Each accepted input byte is loaded straight into the output register, and the payload count increments, saturating at MIN_PAYLOAD.
- TLAST on an accepted payload byte:
  - If PAD_EN=0 or count-after-increment >= MIN_PAYLOAD: o_axis_TLAST=1 on that byte; go to IDLE.
  - Otherwise: o_axis_TLAST=0; go to PAD.
- Input TVALID drop mid-payload: a stall only. The output drains and TVALID deasserts; there is no frame termination.
- PAD: o_axis_TREADY=0. Emits 0x00 per load until the count reaches MIN_PAYLOAD; the final pad byte carries TLAST; then IDLE.
- o_busy clears on the edge where the TLAST byte is accepted (o_axis_TVALID & o_axis_TLAST & i_axis_TREADY).
- Back-to-back frames: a new start may occur in IDLE on the cycle after TLAST was loaded, provided load holds. Throughput is 1 byte/cycle with no inter-frame bubble.
- Header: 14 bytes, total latency 14 cycles to first payload byte under continuous TREADY.
- Frame length out = 14 + max(payload, MIN_PAYLOAD) when PAD_EN=1.
- A zero-length payload is not representable: the first payload beat is always data.

Test Plan:
1. dst=0x665544332211, src=0xCCBBAA998877, type=0x0008, 46-byte payload 0x00..0x2D, TREADY=1 -> 60 bytes out: 11 22 33 44 55 66 77 88 99 AA BB CC 08 00 00..2D; TLAST on byte 60 only; no bubbles.
2. 4-byte payload DE AD BE EF with TLAST -> header, DE AD BE EF, then 42 bytes of 0x00; TLAST on the 60th byte. With PAD_EN=0, TLAST is on the 18th byte (EF).
3. i_specify_mac_en=1, i_mac_addr=0x0A0B0C0D0E0F -> bytes 7-12 = 0F 0E 0D 0C 0B 0A regardless of i_src_mac_addr. Changing i_dst_mac_addr mid-frame does not affect the output.
4. Random i_axis_TREADY (50%) and input TVALID gaps over a 100-byte payload -> no byte dropped or duplicated, TDATA stable while stalled, o_axis_TREADY never high outside PAYLOAD.
5. Two 60-byte frames with input held valid -> the second dst byte0 follows the first TLAST byte on the next cycle; o_busy toggles low only between frames if the start is delayed.
6. Assert reset during payload byte 20 -> next cycle all outputs 0 and state IDLE; a new frame afterwards transmits correctly from dst byte0. Loopback into the receiver recovers the identical dst/src/type.
